// File: rtl/axil_master_pkg.sv
// rtl/axil_master_pkg.sv - shared AXI4-Lite widths, response codes and FSM states for axil_master
package axil_master_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_RESP_WIDTH = 2;

  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    AXIL_MASTER_IDLE            = 3'd0,
    AXIL_MASTER_WRITE_ADDR_DATA = 3'd1,
    AXIL_MASTER_WRITE_RESP      = 3'd2,
    AXIL_MASTER_READ_ADDR       = 3'd3,
    AXIL_MASTER_READ_DATA       = 3'd4,
    AXIL_MASTER_RESPOND         = 3'd5
  } axil_master_state_e;

endpackage

// File: rtl/axil_master.sv
// rtl/axil_master.sv - single-outstanding AXI4-Lite initiator driven by a cmd/rsp valid-ready port
module axil_master
  import axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH     = AXI_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      CLK,
  input  logic                      RST,

  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [AXI_RESP_WIDTH-1:0] rsp_resp,
  output logic                      timeout,

  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,

  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,

  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  input  logic [AXI_RESP_WIDTH-1:0] M_AXI_BRESP,

  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,

  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [AXI_RESP_WIDTH-1:0] M_AXI_RRESP
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  axil_master_state_e state_q, state_d;

  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      aw_valid_q,  aw_valid_d;
  logic                      w_valid_q,   w_valid_d;
  logic                      b_ready_q,   b_ready_d;
  logic                      ar_valid_q,  ar_valid_d;
  logic                      r_ready_q,   r_ready_d;
  logic                      aw_done_q,   aw_done_d;
  logic                      w_done_q,    w_done_d;
  logic [ADDR_WIDTH-1:0]     addr_q,      addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q,     wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q,     wstrb_d;
  logic [DATA_WIDTH-1:0]     rdata_q,     rdata_d;
  logic [AXI_RESP_WIDTH-1:0] resp_q,      resp_d;
  logic [CNT_W-1:0]          cnt_q,       cnt_d;
  logic                      timeout_q,   timeout_d;

  logic aw_hs, w_hs;

  assign aw_hs = aw_valid_q & M_AXI_AWREADY;
  assign w_hs  = w_valid_q  & M_AXI_WREADY;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;

    // The budget only runs while waiting on the slave; the flag never aborts the transfer.
    if (state_q != AXIL_MASTER_IDLE && state_q != AXIL_MASTER_RESPOND) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_d == CNT_MAX) begin
        timeout_d = 1'b1;
      end
    end

    case (state_q)
      AXIL_MASTER_IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          cnt_d       = '0;
          timeout_d   = 1'b0;
          if (cmd_write) begin
            state_d    = AXIL_MASTER_WRITE_ADDR_DATA;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = AXIL_MASTER_READ_ADDR;
            ar_valid_d = 1'b1;
          end
        end
      end

      AXIL_MASTER_WRITE_ADDR_DATA: begin
        aw_done_d  = aw_done_q | aw_hs;
        w_done_d   = w_done_q  | w_hs;
        aw_valid_d = aw_valid_q & ~aw_hs;
        w_valid_d  = w_valid_q  & ~w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = AXIL_MASTER_WRITE_RESP;
          b_ready_d = 1'b1;
        end
      end

      AXIL_MASTER_WRITE_RESP: begin
        if (M_AXI_BVALID && b_ready_q) begin
          state_d     = AXIL_MASTER_RESPOND;
          b_ready_d   = 1'b0;
          resp_d      = M_AXI_BRESP;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
        end
      end

      AXIL_MASTER_READ_ADDR: begin
        if (M_AXI_ARREADY && ar_valid_q) begin
          state_d    = AXIL_MASTER_READ_DATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end

      AXIL_MASTER_READ_DATA: begin
        if (M_AXI_RVALID && r_ready_q) begin
          state_d     = AXIL_MASTER_RESPOND;
          r_ready_d   = 1'b0;
          resp_d      = M_AXI_RRESP;
          rdata_d     = M_AXI_RDATA;
          rsp_valid_d = 1'b1;
        end
      end

      AXIL_MASTER_RESPOND: begin
        if (rsp_ready) begin
          state_d     = AXIL_MASTER_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = AXIL_MASTER_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        aw_valid_d  = 1'b0;
        w_valid_d   = 1'b0;
        b_ready_d   = 1'b0;
        ar_valid_d  = 1'b0;
        r_ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= AXIL_MASTER_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign timeout       = timeout_q;

  assign M_AXI_AWVALID = aw_valid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_WVALID  = w_valid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = b_ready_q;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_RREADY  = r_ready_q;

endmodule
